// File: rtl/alu_stage_pkg.sv
// Shared constants and FSM encoding for the ALU result stage.
package alu_stage_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned HIST_DEPTH = 4;
    localparam int unsigned FB_W       = 4;
    localparam int unsigned HIST_PTR_W = $clog2(HIST_DEPTH);
    localparam int unsigned HIST_CNT_W = HIST_PTR_W + 1;
    localparam int unsigned STATS_W    = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_t;

endpackage

// File: rtl/alu_result_stage_history.sv
// Ring buffer of accepted results: write pointer, saturating count,
// synchronous clear and newest-first indexed read.
module result_history
    import alu_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [HIST_PTR_W-1:0] rd_sel,
    output logic [DATA_W-1:0]     rd_data,
    output logic [HIST_CNT_W-1:0] count
);

    logic [DATA_W-1:0]     r_mem [HIST_DEPTH];
    logic [HIST_PTR_W-1:0] r_wptr;
    logic [HIST_CNT_W-1:0] r_count;
    logic [HIST_PTR_W-1:0] w_idx;

    // Entry storage, pointer and count; a clear that coincides with a write
    // empties the buffer and then stores the new value as entry 0.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_count <= '0;
            if (!rst && wr_en) begin
                r_mem[0] <= wr_data;
                r_wptr   <= HIST_PTR_W'(1);
                r_count  <= HIST_CNT_W'(1);
            end
        end else if (wr_en) begin
            r_mem[r_wptr] <= wr_data;
            r_wptr        <= r_wptr + HIST_PTR_W'(1);
            if (r_count != HIST_CNT_W'(HIST_DEPTH)) begin
                r_count <= r_count + HIST_CNT_W'(1);
            end
        end
    end

    // Newest-first read; indices beyond the valid entries read as zero.
    always_comb begin
        w_idx   = r_wptr - HIST_PTR_W'(1) - rd_sel;
        rd_data = '0;
        if (HIST_CNT_W'(rd_sel) < r_count) begin
            rd_data = r_mem[w_idx];
        end
    end

    assign count = r_count;

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: valid/ready output register, B-operand
// feedback register and result history.
// Optional build macro RESULT_STATS_EN adds a saturating accept counter.
module alu_result_stage
    import alu_stage_pkg::*;
(
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DATA_W-1:0]     alu_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FB_W-1:0]       fb_operand,
    input  logic [HIST_PTR_W-1:0] hist_sel,
    output logic [DATA_W-1:0]     hist_data,
    output logic [HIST_CNT_W-1:0] hist_count,
    input  logic                  hist_clr
`ifdef RESULT_STATS_EN
    ,
    output logic [STATS_W-1:0]    accept_cnt
`endif
);

    stage_state_t r_state;
    stage_state_t w_state_nxt;
    logic         w_accept;
    logic         w_consume;

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: fill on accept, drain on a consume with no refill.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL:  if (w_consume && !w_accept) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // Handshake outputs; in_ready never depends on in_valid.
    always_comb begin
        out_valid = (r_state == ST_FULL);
        in_ready  = (r_state == ST_EMPTY) || out_ready;
        w_accept  = in_valid && in_ready;
        w_consume = out_valid && out_ready;
    end

    // Output and feedback registers load only on accept, so data holds while stalled.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            out_data   <= '0;
            fb_operand <= '0;
        end else if (w_accept) begin
            out_data   <= alu_in;
            fb_operand <= alu_in[FB_W-1:0];
        end
    end

    result_history u_history (
        .clk     (Clock),
        .rst     (Reset),
        .clr     (hist_clr),
        .wr_en   (w_accept),
        .wr_data (alu_in),
        .rd_sel  (hist_sel),
        .rd_data (hist_data),
        .count   (hist_count)
    );

`ifdef RESULT_STATS_EN
    // Saturating count of accepted results; only Reset clears it.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            accept_cnt <= '0;
        end else if (w_accept && (accept_cnt != {STATS_W{1'b1}})) begin
            accept_cnt <= accept_cnt + STATS_W'(1);
        end
    end
`endif

endmodule
